// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the EX stage and the multiply/divide unit.
//
// Handshake: start is a single-cycle request qualifier for mdu_op/a/b. A request
// is accepted on a rising edge only when busy is low during that cycle; a
// request seen while busy is high is dropped, with no retry and no side effect.
// After a MULT/DIV class accept, busy stays high for the op's full latency.
// hi/lo carry the new result in the first cycle in which busy is low again.
// stall_req lets the hazard unit freeze any MDU-using instruction in D.
interface mdu_if;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mdu_op, a, b,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  start, mdu_op, a, b,
        output busy, stall_req, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit that owns the HI/LO pair.
// The result is computed when the op is accepted and is held in a pending
// register. A down-counter then stretches the op over a fixed latency, and
// HI/LO are written on the edge where the counter reaches zero.
// Optional feature: define MDU_MADD_EN to build MADD/MADDU, which accumulate
// into {hi,lo}. When it is not defined, those opcodes decode as NONE.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic   clk,
    input logic   reset,
    mdu_if.slave  bus
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;

    logic [3:0]  cnt;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic        p_wr;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy;

    logic        is_mult;
    logic        is_div;
    logic        is_madd;
    logic        mul_class;
    logic [63:0] mul_s;
    logic [63:0] mul_u;
    logic [63:0] mul_res;
    logic [63:0] div_res;
    logic [31:0] divisor;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] dq;
    logic [31:0] dr;

    assign is_mult = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU);
    assign is_div  = (bus.mdu_op == OP_DIV)  || (bus.mdu_op == OP_DIVU);
`ifdef MDU_MADD_EN
    assign is_madd = (bus.mdu_op == OP_MADD) || (bus.mdu_op == OP_MADDU);
`else
    assign is_madd = 1'b0;
`endif
    assign mul_class = is_mult | is_madd;

    assign busy          = (cnt != 4'd0);
    assign bus.busy      = busy;
    assign bus.stall_req = busy | (bus.start & (mul_class | is_div));
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

    // Full 64-bit products. Sign-extending to 64 bits gives the signed form.
    assign mul_s = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
    assign mul_u = {32'd0, bus.a} * {32'd0, bus.b};

    // Select the product, or the product added onto {hi,lo} for accumulate ops.
    always_comb begin
        mul_res = (bus.mdu_op == OP_MULTU) ? mul_u : mul_s;
`ifdef MDU_MADD_EN
        if (bus.mdu_op == OP_MADD) begin
            mul_res = {hi_q, lo_q} + mul_s;
        end else if (bus.mdu_op == OP_MADDU) begin
            mul_res = {hi_q, lo_q} + mul_u;
        end
`endif
    end

    // Divide on magnitudes, then restore the signs. This keeps 0x80000000 / -1
    // well defined, because the negation wraps back to 0x80000000.
    always_comb begin
        divisor = (bus.b == 32'd0) ? 32'd1 : bus.b;
        abs_a   = bus.a;
        abs_b   = divisor;
        if (bus.mdu_op == OP_DIV) begin
            abs_a = bus.a[31] ? -bus.a : bus.a;
            abs_b = bus.b[31] ? -divisor : divisor;
        end
        uq = abs_a / abs_b;
        ur = abs_a % abs_b;
        dq = uq;
        dr = ur;
        if (bus.mdu_op == OP_DIV) begin
            dq = (bus.a[31] ^ bus.b[31]) ? -uq : uq;
            dr = bus.a[31] ? -ur : ur;
        end
        div_res = {dr, dq};
    end

    // Accept new ops when idle, count down while busy, and commit on the last edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= 4'd0;
            p_hi <= 32'd0;
            p_lo <= 32'd0;
            p_wr <= 1'b0;
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (busy) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1 && p_wr) begin
                hi_q <= p_hi;
                lo_q <= p_lo;
            end
        end else if (bus.start) begin
            if (mul_class) begin
                cnt          <= 4'(MULT_CYCLES);
                {p_hi, p_lo} <= mul_res;
                p_wr         <= 1'b1;
            end else if (is_div) begin
                cnt          <= 4'(DIV_CYCLES);
                {p_hi, p_lo} <= div_res;
                p_wr         <= (bus.b != 32'd0);
            end else if (bus.mdu_op == OP_MTHI) begin
                hi_q <= bus.a;
            end else if (bus.mdu_op == OP_MTLO) begin
                lo_q <= bus.a;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized checks of mul_div_unit against a
// plain-arithmetic model of HI/LO and op latency.
module tb_mul_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;
    mdu_if bus ();

    mul_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns the {hi,lo} expected after the op, and how many cycles busy stays high.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output int lat, output logic [63:0] res);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uqv, urv;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        res = {m_hi, m_lo};
        lat = 0;
        case (op)
            4'd1: begin lat = MULT_N; res = sa * sb; end
            4'd2: begin lat = MULT_N; res = ua * ub; end
            4'd3: begin
                lat = DIV_N;
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            4'd4: begin
                lat = DIV_N;
                if (b != 0) begin
                    uqv = ua / ub;
                    urv = ua % ub;
                    res = {urv[31:0], uqv[31:0]};
                end
            end
            4'd5: res = {a, m_lo};
            4'd6: res = {m_hi, a};
`ifdef MDU_MADD_EN
            4'd7: begin lat = MULT_N; res = {m_hi, m_lo} + 64'(sa * sb); end
            4'd8: begin lat = MULT_N; res = {m_hi, m_lo} + 64'(ua * ub); end
`endif
            default: ;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Issue one op. During the busy period the operand inputs are scrambled,
    // and optionally a stray start is injected at cycle inj_cyc (or at random when noisy).
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int inj_cyc, input logic [3:0] inj_op,
                          input logic [31:0] inj_a, input bit noisy);
        int lat, cycles;
        logic [63:0] res, got_exp;
        model(op, a, b, lat, res);
        exp_q.push_back(res);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mdu_op = op;
        bus.a      = a;
        bus.b      = b;
        #1;
        check({tag, ".stall_issue"}, 64'(bus.stall_req), 64'(lat != 0));
        @(negedge clk);
        bus.start = 1'b0;
        cycles = 0;
        while (bus.busy && cycles < 40) begin
            check({tag, ".stall_busy"}, 64'(bus.stall_req), 64'd1);
            bus.a      = $urandom;
            bus.b      = $urandom;
            bus.mdu_op = 4'($urandom_range(0, 15));
            bus.start  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (cycles == inj_cyc) begin
                bus.start  = 1'b1;
                bus.mdu_op = inj_op;
                bus.a      = inj_a;
            end
            cycles++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, ".busy_cycles"}, 64'(cycles), 64'(lat));
        got_exp = exp_q.pop_front();
        check({tag, ".hi"}, 64'(bus.hi), 64'(got_exp[63:32]));
        check({tag, ".lo"}, 64'(bus.lo), 64'(got_exp[31:0]));
        m_hi = got_exp[63:32];
        m_lo = got_exp[31:0];
    endtask

    task automatic simple(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        run_op(tag, op, a, b, -1, 4'd0, 32'd0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  rop;
        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.mdu_op = 4'd0;
        bus.a      = '0;
        bus.b      = '0;
        repeat (3) @(negedge clk);
        check("rst.busy", 64'(bus.busy), 64'd0);
        check("rst.hi", 64'(bus.hi), 64'd0);
        check("rst.lo", 64'(bus.lo), 64'd0);
        reset = 1'b1;

        // Reset aborts an in-flight DIV asynchronously.
        simple("mthi_pre", 4'd5, 32'h1234, 32'd0);
        simple("mtlo_pre", 4'd6, 32'h5678, 32'd0);
        @(negedge clk);
        bus.start = 1'b1; bus.mdu_op = 4'd3; bus.a = 32'd100; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort.busy", 64'(bus.busy), 64'd0);
        check("abort.hi", 64'(bus.hi), 64'd0);
        check("abort.lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        check("abort.hi_after", 64'(bus.hi), 64'd0);

        // Directed cases.
        simple("mult", 4'd1, 32'hFFFFFFFE, 32'd3);
        check("mult.hi_const", 64'(bus.hi), 64'hFFFFFFFF);
        check("mult.lo_const", 64'(bus.lo), 64'hFFFFFFFA);
        simple("multu", 4'd2, 32'hFFFFFFFE, 32'd3);
        check("multu.hi_const", 64'(bus.hi), 64'h2);
        simple("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2);
        check("div_neg.lo_const", 64'(bus.lo), 64'hFFFFFFFD);
        check("div_neg.hi_const", 64'(bus.hi), 64'hFFFFFFFF);
        simple("divu", 4'd4, 32'd7, 32'd2);
        simple("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf.lo_const", 64'(bus.lo), 64'h80000000);
        simple("mthi11", 4'd5, 32'h11, 32'd0);
        simple("mtlo22", 4'd6, 32'h22, 32'd0);
        simple("div0", 4'd3, 32'd99, 32'd0);
        check("div0.hi_const", 64'(bus.hi), 64'h11);
        check("div0.lo_const", 64'(bus.lo), 64'h22);
        run_op("mult_mthi", 4'd1, 32'd1000, 32'd77, 1, 4'd5, 32'hABCD, 1'b0);
        simple("mtlo5", 4'd6, 32'd5, 32'd0);
        check("mtlo5.busy", 64'(bus.busy), 64'd0);
        simple("mthi0", 4'd5, 32'd0, 32'd0);
        simple("mtlo_ff", 4'd6, 32'hFFFFFFFF, 32'd0);
        simple("maddu", 4'd8, 32'd1, 32'd1);
        simple("madd", 4'd7, 32'hFFFFFFFF, 32'd3);
        simple("undef", 4'd12, 32'h1, 32'h2);

        // Randomized ops with scrambled operands and stray starts during busy.
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op("rand", rop, ra, rb, -1, 4'd0, 32'd0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
